// File: rtl/alarm_sounder.sv
// alarm_sounder: turns the "alarm time == current time" level into a ring
// session that drives a piezo buzzer. It supports a limited number of
// snoozes, stop/dismiss, and an automatic timeout.
//
// Optional build macro ALARM_ESCALATE_EN: once a RINGING episode has seen
// 10 ticks, the tone stops alternating by second and sounds continuously
// until the episode leaves RINGING. When the macro is undefined, the tone
// alternates every second for the whole episode.
module alarm_sounder #(
   parameter int unsigned TONE_DIV          = 25000,
   parameter int unsigned RING_TIMEOUT_SECS = 60,
   parameter int unsigned SNOOZE_SECS       = 300,
   parameter int unsigned MAX_SNOOZES       = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        tick_1hz,
   input  logic        alarm_match,
   input  logic        alarm_enable,
   input  logic        snooze_press,
   input  logic        stop_press,
   output logic        buzzer,
   output logic        ringing,
   output logic        snoozing,
   output logic [1:0]  snooze_count,
   output logic [15:0] snooze_left
);

   // Out-of-range parameters are clamped into the legal range so the
   // counters always have a sane width.
   localparam int unsigned TD_CLAMP = (TONE_DIV < 1) ? 1 : TONE_DIV;
   localparam int          TD_W     = (TD_CLAMP > 1) ? $clog2(TD_CLAMP) : 1;
   localparam logic [TD_W-1:0] TD_LAST = TD_W'(TD_CLAMP - 1);

   localparam int unsigned ESC_SECS = 10;
   localparam int unsigned TO_CLAMP = (RING_TIMEOUT_SECS < 1) ? 1 : RING_TIMEOUT_SECS;
   // ring_secs must reach both the timeout and the escalation point.
   localparam int unsigned RS_MAX   = (TO_CLAMP > ESC_SECS) ? TO_CLAMP : ESC_SECS;
   localparam int          RS_W     = $clog2(RS_MAX + 1);
   localparam logic [RS_W-1:0] RS_TIMEOUT = RS_W'(TO_CLAMP);
   localparam logic [RS_W-1:0] RS_SAT     = RS_W'(RS_MAX);

   localparam int unsigned SN_CLAMP = (SNOOZE_SECS < 1) ? 1 :
                                      (SNOOZE_SECS > 65535) ? 65535 : SNOOZE_SECS;
   localparam logic [15:0] SN_LOAD  = 16'(SN_CLAMP);
   localparam logic [1:0]  MAX_SN   = 2'((MAX_SNOOZES > 3) ? 3 : MAX_SNOOZES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RINGING,
      S_SNOOZE,
      S_DISMISSED
   } state_t;

   state_t          state;
   logic            match_q;
   logic            primed;
   logic [RS_W-1:0] ring_secs;
   logic            beep_phase;
   logic [TD_W-1:0] tone_cnt;
   logic            tone;

   logic            match_rise;
   logic            snooze_ok;
   logic [RS_W-1:0] ring_secs_inc;
   logic            beep_on_tick;

   // match_q is only trusted after one edge out of reset, so a match that
   // is already high when reset releases is never mistaken for a rising edge.
   assign match_rise = alarm_match && !match_q && primed;

   // Snooze is available only while the session has snoozes left.
   assign snooze_ok = (snooze_count < MAX_SN);

   // The seconds counter saturates instead of wrapping.
   assign ring_secs_inc = (ring_secs == RS_SAT) ? RS_SAT : ring_secs + RS_W'(1);

`ifdef ALARM_ESCALATE_EN
   localparam logic [RS_W-1:0] RS_ESC = RS_W'(ESC_SECS);
   // From the escalation tick onward the beep stays on.
   assign beep_on_tick = (ring_secs_inc >= RS_ESC) ? 1'b1 : !beep_phase;
`else
   // The beep alternates every second.
   assign beep_on_tick = !beep_phase;
`endif

   // Ring-session FSM: it updates the state, the session counters and the
   // registered status outputs together.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= S_IDLE;
         match_q      <= 1'b0;
         primed       <= 1'b0;
         ring_secs    <= '0;
         beep_phase   <= 1'b0;
         ringing      <= 1'b0;
         snoozing     <= 1'b0;
         snooze_count <= 2'd0;
         snooze_left  <= 16'd0;
      end else begin
         match_q <= alarm_match;
         primed  <= 1'b1;
         if (!alarm_enable) begin
            // Disarming wins over everything and wipes the session.
            state        <= S_IDLE;
            ringing      <= 1'b0;
            snoozing     <= 1'b0;
            ring_secs    <= '0;
            beep_phase   <= 1'b0;
            snooze_count <= 2'd0;
            snooze_left  <= 16'd0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (match_rise) begin
                     state        <= S_RINGING;
                     ringing      <= 1'b1;
                     ring_secs    <= '0;
                     beep_phase   <= 1'b1;
                     snooze_count <= 2'd0;
                  end
               end

               S_RINGING: begin
                  if (stop_press) begin
                     state      <= S_DISMISSED;
                     ringing    <= 1'b0;
                     beep_phase <= 1'b0;
                  end else if (snooze_press && snooze_ok) begin
                     // A simultaneous tick is swallowed by the snooze load.
                     state        <= S_SNOOZE;
                     ringing      <= 1'b0;
                     snoozing     <= 1'b1;
                     beep_phase   <= 1'b0;
                     snooze_left  <= SN_LOAD;
                     snooze_count <= snooze_count + 2'd1;
                  end else if (tick_1hz) begin
                     ring_secs <= ring_secs_inc;
                     if (ring_secs_inc >= RS_TIMEOUT) begin
                        state      <= S_DISMISSED;
                        ringing    <= 1'b0;
                        beep_phase <= 1'b0;
                     end else begin
                        beep_phase <= beep_on_tick;
                     end
                  end
               end

               S_SNOOZE: begin
                  if (stop_press) begin
                     state       <= S_DISMISSED;
                     snoozing    <= 1'b0;
                     snooze_left <= 16'd0;
                  end else if (tick_1hz) begin
                     if (snooze_left <= 16'd1) begin
                        // The snooze has expired: a fresh ringing episode
                        // starts, keeping the snoozes already used.
                        state       <= S_RINGING;
                        ringing     <= 1'b1;
                        snoozing    <= 1'b0;
                        snooze_left <= 16'd0;
                        ring_secs   <= '0;
                        beep_phase  <= 1'b1;
                     end else begin
                        snooze_left <= snooze_left - 16'd1;
                     end
                  end
               end

               S_DISMISSED: begin
                  // Wait out the matched minute so the alarm cannot re-ring.
                  if (!alarm_match) begin
                     state <= S_IDLE;
                  end
               end

               default: begin
                  state    <= S_IDLE;
                  ringing  <= 1'b0;
                  snoozing <= 1'b0;
               end
            endcase
         end
      end
   end

   // Tone divider: it free-runs only while ringing and flips the tone at
   // each wrap.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tone_cnt <= '0;
         tone     <= 1'b0;
      end else if (ringing) begin
         if (tone_cnt == TD_LAST) begin
            tone_cnt <= '0;
            tone     <= !tone;
         end else begin
            tone_cnt <= tone_cnt + TD_W'(1);
         end
      end else begin
         tone_cnt <= '0;
         tone     <= 1'b0;
      end
   end

   // The buzzer pin comes straight from a flop so that it cannot glitch.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         buzzer <= 1'b0;
      end else begin
         buzzer <= ringing && beep_phase && tone;
      end
   end

endmodule

// File: tb/tb_alarm_sounder.sv
// tb_alarm_sounder: directed stimulus for alarm_sounder. A session-level
// model runs alongside the DUT and is compared on every falling edge.
// Literal checks pin the key values of each scenario.
module tb_alarm_sounder;

   localparam int TD  = 2;
`ifdef ALARM_ESCALATE_EN
   localparam int TO  = 20;
`else
   localparam int TO  = 5;
`endif
   localparam int SS  = 3;
   localparam int MAXS = 2;

   logic        clk;
   logic        resetn;
   logic        tick_1hz;
   logic        alarm_match;
   logic        alarm_enable;
   logic        snooze_press;
   logic        stop_press;
   logic        buzzer;
   logic        ringing;
   logic        snoozing;
   logic [1:0]  snooze_count;
   logic [15:0] snooze_left;

   int tests_run = 0;
   int tests_failed = 0;

   alarm_sounder #(
      .TONE_DIV(TD),
      .RING_TIMEOUT_SECS(TO),
      .SNOOZE_SECS(SS),
      .MAX_SNOOZES(MAXS)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .tick_1hz(tick_1hz),
      .alarm_match(alarm_match),
      .alarm_enable(alarm_enable),
      .snooze_press(snooze_press),
      .stop_press(stop_press),
      .buzzer(buzzer),
      .ringing(ringing),
      .snoozing(snoozing),
      .snooze_count(snooze_count),
      .snooze_left(snooze_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- session-level model ----------------
   localparam int M_IDLE = 0;
   localparam int M_RING = 1;
   localparam int M_SNZ  = 2;
   localparam int M_DIS  = 3;

   int m_st;
   int m_secs;      // ticks seen in the current ringing episode
   int m_left;      // snooze seconds remaining
   int m_count;     // snoozes used in the session
   int m_k;         // consecutive clock edges spent ringing
   bit m_buz;
   bit m_match_q;
   bit m_primed;
   bit m_rise;

   // Beep on even seconds of the episode; with escalation, always on from 10 s onward.
   function automatic bit beep_of(input int s);
`ifdef ALARM_ESCALATE_EN
      if (s >= 10) return 1'b1;
`endif
      return (s % 2) == 0;
   endfunction

   // The tone is a square wave of period 2*TD edges, counted from the start of ringing.
   function automatic bit tone_of(input int k);
      return ((k / TD) % 2) == 1;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_st = M_IDLE; m_secs = 0; m_left = 0; m_count = 0; m_k = 0;
         m_buz = 1'b0; m_match_q = 1'b0; m_primed = 1'b0;
      end else begin
         m_rise = alarm_match && !m_match_q && m_primed;
         m_buz  = (m_st == M_RING) && beep_of(m_secs) && tone_of(m_k);
         m_k    = (m_st == M_RING) ? m_k + 1 : 0;
         if (!alarm_enable) begin
            m_st = M_IDLE; m_left = 0; m_count = 0;
         end else begin
            case (m_st)
               M_IDLE: if (m_rise) begin
                  m_st = M_RING; m_secs = 0; m_count = 0;
               end
               M_RING: begin
                  if (stop_press) m_st = M_DIS;
                  else if (snooze_press && m_count < MAXS) begin
                     m_st = M_SNZ; m_left = SS; m_count = m_count + 1;
                  end else if (tick_1hz) begin
                     m_secs = m_secs + 1;
                     if (m_secs >= TO) m_st = M_DIS;
                  end
               end
               M_SNZ: begin
                  if (stop_press) begin
                     m_st = M_DIS; m_left = 0;
                  end else if (tick_1hz) begin
                     m_left = m_left - 1;
                     if (m_left == 0) begin
                        m_st = M_RING; m_secs = 0;
                     end
                  end
               end
               default: if (!alarm_match) m_st = M_IDLE;
            endcase
         end
         m_match_q = alarm_match;
         m_primed  = 1'b1;
      end
   end

   // ---------------- checking ----------------
   task automatic cmp(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("[TB] %s ok (%0d)", name, act);
      end
   endtask

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      cmp("model_ringing",  int'(ringing),      int'(m_st == M_RING));
      cmp("model_snoozing", int'(snoozing),     int'(m_st == M_SNZ));
      cmp("model_count",    int'(snooze_count), m_count);
      cmp("model_left",     int'(snooze_left),  m_left);
      cmp("model_buzzer",   int'(buzzer),       int'(m_buz));
   end

   // ---------------- stimulus ----------------
   task automatic pulse(input bit t, input bit s, input bit p);
      tick_1hz = t; snooze_press = s; stop_press = p;
      @(posedge clk); #1;
      tick_1hz = 1'b0; snooze_press = 1'b0; stop_press = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) pulse(1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle_count(input int n, output int c);
      c = 0;
      repeat (n) begin
         pulse(1'b0, 1'b0, 1'b0);
         if (buzzer) c++;
      end
   endtask

   // Drop the match and raise it again to start a new session.
   task automatic rearm();
      alarm_match = 1'b0; pulse(1'b0, 1'b0, 1'b0);
      alarm_match = 1'b1; pulse(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int c;
      resetn = 1'b0; alarm_enable = 1'b0; alarm_match = 1'b0;
      tick_1hz = 1'b0; snooze_press = 1'b0; stop_press = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ringing", int'(ringing), 0);
      check("reset_buzzer",  int'(buzzer), 0);
      check("reset_left",    int'(snooze_left), 0);
      resetn = 1'b1;
      alarm_enable = 1'b1;
      idle(2);

      // T1: ring on the rising edge of the match, then time out.
      alarm_match = 1'b1; pulse(1'b0, 1'b0, 1'b0);
      check("t1_ring_start", int'(ringing), 1);
      idle_count(4, c);
      check("t1_buzz_beep_on", c, 2);
      pulse(1'b1, 1'b0, 1'b0);
      idle_count(4, c);
      check("t1_buzz_beep_off", c, 0);
      pulse(1'b1, 1'b0, 1'b0);
      for (int i = 3; i < TO; i++) begin
         idle(4); pulse(1'b1, 1'b0, 1'b0);
      end
      check("t1_before_timeout", int'(ringing), 1);
      idle(4); pulse(1'b1, 1'b0, 1'b0);
      check("t1_timeout", int'(ringing), 0);
      idle(3);
      check("t1_stay_off_match_high", int'(ringing), 0);

      // T2: snooze, countdown, and return to ringing.
      rearm();
      check("t2_ring", int'(ringing), 1);
      idle(2); pulse(1'b0, 1'b1, 1'b0);
      check("t2_snoozing", int'(snoozing), 1);
      check("t2_left_load", int'(snooze_left), 3);
      check("t2_count", int'(snooze_count), 1);
      idle(2); pulse(1'b0, 1'b1, 1'b0);
      check("t2_snooze_in_snooze_ignored", int'(snooze_left), 3);
      pulse(1'b1, 1'b0, 1'b0);
      check("t2_left_2", int'(snooze_left), 2);
      idle(2); pulse(1'b1, 1'b0, 1'b0);
      check("t2_left_1", int'(snooze_left), 1);
      idle(2); pulse(1'b1, 1'b0, 1'b0);
      check("t2_back_ringing", int'(ringing), 1);
      check("t2_left_0", int'(snooze_left), 0);

      // T3: a snooze with a tick in the same cycle, then the limit is reached.
      idle(2); pulse(1'b1, 1'b1, 1'b0);
      check("t3_snooze_with_tick_left", int'(snooze_left), 3);
      check("t3_count_2", int'(snooze_count), 2);
      for (int i = 0; i < SS; i++) begin
         idle(2); pulse(1'b1, 1'b0, 1'b0);
      end
      check("t3_ringing_again", int'(ringing), 1);
      idle(2); pulse(1'b0, 1'b1, 1'b0);
      check("t3_limit_ignored_ringing", int'(ringing), 1);
      check("t3_limit_count", int'(snooze_count), 2);
      pulse(1'b1, 1'b1, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      check("t3_stop", int'(ringing), 0);
      check("t3_count_kept", int'(snooze_count), 2);

      // T4: snooze and stop in the same cycle go to dismiss.
      rearm();
      check("t4_new_session_count", int'(snooze_count), 0);
      idle(3); pulse(1'b0, 1'b1, 1'b1);
      check("t4_dismissed", int'(ringing), 0);
      check("t4_not_snoozing", int'(snoozing), 0);
      check("t4_count_unchanged", int'(snooze_count), 0);
      idle(1);
      idle_count(4, c);
      check("t4_buzzer_silent", c, 0);

      // T5: disarming in mid-snooze.
      rearm();
      pulse(1'b0, 1'b1, 1'b0);
      idle(1); pulse(1'b1, 1'b0, 1'b0);
      check("t5_left_2", int'(snooze_left), 2);
      alarm_enable = 1'b0; pulse(1'b0, 1'b0, 1'b0);
      check("t5_disable_snoozing", int'(snoozing), 0);
      check("t5_disable_left", int'(snooze_left), 0);
      check("t5_disable_count", int'(snooze_count), 0);
      alarm_enable = 1'b1; idle(5);
      check("t5_no_rering", int'(ringing), 0);

      // T6: asynchronous reset in mid-ringing.
      rearm();
      idle(3);
      #2 resetn = 1'b0;
      #1;
      check("t6_async_ringing", int'(ringing), 0);
      check("t6_async_buzzer", int'(buzzer), 0);
      check("t6_async_count", int'(snooze_count), 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      idle(4);
      check("t6_no_ring_after_reset", int'(ringing), 0);

`ifdef ALARM_ESCALATE_EN
      // Escalation: after tick 10 there is no silent second.
      rearm();
      for (int i = 0; i < 11; i++) begin
         idle(4); pulse(1'b1, 1'b0, 1'b0);
      end
      idle_count(4, c);
      check("esc_tone_after_11", int'(c > 0), 1);
      check("esc_still_ringing", int'(ringing), 1);
`endif

      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/alarm_sounder.md
Name: alarm_sounder

Overview:
- Downstream consumer of the clock top's alarm_ring comparison and 1 Hz inc tick.
- Turns the level "alarm time == current time" into a ring session that drives a piezo buzzer.
- Provides snooze with a limit, stop/dismiss, and auto-timeout.
- Sits between the alarm_clock top and the board buzzer pin / status LEDs.

Parameters:
- TONE_DIV, 25000, clk cycles per buzzer tone half-period (1 kHz at 50 MHz); must be ≥1.
- RING_TIMEOUT_SECS, 60, seconds of continuous RINGING before auto-dismiss; must be ≥1.
- SNOOZE_SECS, 300, snooze duration in seconds; must be ≥1 and ≤65535.
- MAX_SNOOZES, 3, snoozes allowed per ring session; 0 disables snooze.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- tick_1hz  input  1  one-cycle pulse, once per second (sec_counter inc)
- alarm_match  input  1  level; high while the alarm registers equal the current hour and minute
- alarm_enable  input  1  level; alarm armed
- snooze_press  input  1  one-cycle pulse from press_detector
- stop_press  input  1  one-cycle pulse from press_detector
- buzzer  output  1  tone output to the piezo
- ringing  output  1  state == RINGING
- snoozing  output  1  state == SNOOZE
- snooze_count  output  2  snoozes used in the current session, saturating at MAX_SNOOZES
- snooze_left  output  16  seconds remaining in the snooze; 0 outside SNOOZE

Behaviour:
- Reset (async, resetn low): state IDLE; all outputs 0; match_q 0; tone divider 0; beep_phase 0.
- match_q registers alarm_match every cycle; match_rise = alarm_match && !match_q.
- IDLE -> RINGING on match_rise && alarm_enable.
  - On entry: ring_secs=0, beep_phase=1, snooze_count=0.
- RINGING:
  - stop_press -> DISMISSED.
  - Else snooze_press && snooze_count<MAX_SNOOZES -> SNOOZE; snooze_left=SNOOZE_SECS; snooze_count+1.
  - snooze_press with the limit reached is ignored; stay RINGING.
  - Else on tick_1hz: ring_secs+1 and beep_phase toggles.
  - When ring_secs reaches RING_TIMEOUT_SECS -> DISMISSED (transition on the same cycle as that tick).
- SNOOZE:
  - stop_press -> DISMISSED.
  - On tick_1hz: snooze_left-1.
  - The tick that makes snooze_left 0 -> RINGING with ring_secs=0, beep_phase=1; snooze_count retained.
  - match_rise is ignored.
- DISMISSED -> IDLE on the first cycle alarm_match is low. This prevents re-ringing within the matched minute.
- alarm_enable low: any state -> IDLE on the next edge; snooze_left and snooze_count clear. Has top priority after reset.
- Priority within a cycle: !alarm_enable > stop_press > snooze_press > tick_1hz.
  - A snooze_press on the same cycle as a tick takes the load; no decrement that cycle.
- Tone divider:
  - Free-runs only while ringing; counts 0..TONE_DIV-1, toggling tone at wrap.
  - Cleared to 0 with tone=0 when not ringing.
- buzzer = ringing && beep_phase && tone, driven from a register (one cycle after the tone toggle). Glitch-free.
- Latency: state, ringing and snoozing update on the clock edge that samples the event (1 cycle).
- Counters saturate rather than wrap; snooze_left never underflows.
- Reset asserted mid-session aborts immediately to IDLE.
- On deassertion, an alarm_match that is already high does not ring (match_q captures it first). This is accepted.

Optional Feature:
- Macro: ALARM_ESCALATE_EN.
- Defined: after 10 ticks in the current RINGING episode, beep_phase is forced to 1 (continuous tone) until the episode leaves RINGING.
- Undefined: beep_phase alternates every second for the whole episode.

Test Plan (TONE_DIV=2, RING_TIMEOUT_SECS=5, SNOOZE_SECS=3, MAX_SNOOZES=2):
- Enable=1, raise alarm_match -> ringing=1 next cycle; buzzer toggles every 2 clks during the beep_phase=1 seconds and stays 0 during the alternate seconds. After 5 ticks -> ringing=0; stays off with match still high; IDLE once match drops.
- Ringing, snooze_press -> snoozing=1, snooze_left=3, snooze_count=1. Ticks show 2, 1, then ringing=1 on the third tick with snooze_left=0.
- Snooze twice, then a third snooze_press while ringing -> ignored; ringing stays 1, snooze_count=2.
- snooze_press and stop_press in the same cycle while ringing -> DISMISSED; snooze_count unchanged; buzzer=0.
- alarm_enable dropped mid-SNOOZE with snooze_left=2 -> IDLE; snooze_left=0, snooze_count=0. Re-enable with match held high -> no ring.
- resetn pulsed low mid-RINGING -> all outputs 0 asynchronously. With ALARM_ESCALATE_EN, RING_TIMEOUT_SECS=20: after tick 10, buzzer toggles without a silent second.
